// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search engine:
// FSM state encoding, legal WIDTH range and the probe-index width helper.
package sar_search_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 8;

    // Index counts WIDTH-1 down to 0; never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sar_search_mask_shift.sv
// One-hot probe mask: loads the MSB, shifts right once per probe,
// and flags when the bit currently under test is bit 0.
module sar_search_mask_shift #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    output logic [WIDTH-1:0] mask_o,
    output logic             last_o
);

    logic [WIDTH-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (load_i) begin
            mask_d = {1'b1, {(WIDTH-1){1'b0}}};
        end else if (shift_i) begin
            mask_d = mask_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_o = mask_q;
    assign last_o = mask_q[0];

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search: probes an external less-than comparator
// MSB-first and recovers the unknown target code in WIDTH probe cycles.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = idx_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mask_load, mask_shift, mask_last;
    logic [WIDTH-1:0] mask;

    sar_search_mask_shift #(.WIDTH(WIDTH)) u_mask (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (mask_load),
        .shift_i (mask_shift),
        .mask_o  (mask),
        .last_o  (mask_last)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        result_d   = result_q;
        idx_d      = idx_q;
        mask_load  = 1'b0;
        mask_shift = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // A start in DONE restarts immediately for back-to-back searches.
                if (start) begin
                    state_d   = S_PROBE;
                    acc_d     = '0;
                    idx_d     = IDX_W'(WIDTH - 1);
                    mask_load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PROBE: begin
                acc_d      = cmp_lt ? acc_q : (acc_q | mask);
                mask_shift = 1'b1;
                idx_d      = idx_q - 1'b1;
                if (mask_last && (idx_q == '0)) begin
                    state_d  = S_DONE;
                    result_d = acc_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            idx_q    <= idx_d;
        end
    end

    assign busy   = (state_q == S_PROBE);
    assign done   = (state_q == S_DONE);
    assign trial  = busy ? (acc_q | mask) : '0;
    assign result = result_q;

endmodule
